// File: rtl/mouse_device_sm.sv
`default_nettype none
// ============================================================================
// Module   : mouse_device_sm
// Purpose  : Device-side PS/2 mouse responder: sends BAT, answers host
//            commands and streams 3-byte movement packets.
//            Optional MOUSE_DEV_SETRATE_EN adds the F3 set-sample-rate command.
// Revision : 1.0 - initial release
// ============================================================================
module mouse_device_sm #(
    parameter logic [15:0] BAT_DELAY  = 16'd49_999,
    parameter logic [15:0] TX_TIMEOUT = 16'd49_999
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    input  logic       MOVE_VALID,
    input  logic [7:0] MOVE_STATUS,
    input  logic [7:0] MOVE_DX,
    input  logic [7:0] MOVE_DY,
    output logic       MOVE_ACCEPT,
    output logic       STREAM_EN,
    output logic [7:0] SAMPLE_RATE
);

    localparam logic [2:0] S_BAT_WAIT = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_TX_LOAD  = 3'd2;
    localparam logic [2:0] S_TX_WAIT  = 3'd3;
`ifdef MOUSE_DEV_SETRATE_EN
    localparam logic [2:0] S_WAIT_ARG = 3'd4;
`endif

    localparam logic [7:0] c_ACK       = 8'hFA;
    localparam logic [7:0] c_RESEND    = 8'hFE;
    localparam logic [7:0] c_BAT_OK    = 8'hAA;
    localparam logic [7:0] c_DEV_ID    = 8'h00;
    localparam logic [7:0] c_RATE_DFLT = 8'h64;

    logic [2:0]  r_state;
    logic [23:0] r_q_buf;
    logic [1:0]  r_q_cnt;
    logic [15:0] r_bat_cnt;
    logic [15:0] r_to_cnt;
    logic        r_send_byte;
    logic [7:0]  r_byte_to_send;
    logic        r_read_enable;
    logic        r_move_accept;
    logic        r_stream_en;
    logic [7:0]  r_sample_rate;
`ifdef MOUSE_DEV_SETRATE_EN
    logic        r_arg_pend;
    logic        w_arg_nxt;
`endif

    logic [23:0] w_rsp_buf;
    logic [1:0]  w_rsp_cnt;
    logic        w_stream_nxt;
    logic [7:0]  w_rate_nxt;

    assign SEND_BYTE    = r_send_byte;
    assign BYTE_TO_SEND = r_byte_to_send;
    assign READ_ENABLE  = r_read_enable;
    assign MOVE_ACCEPT  = r_move_accept;
    assign STREAM_EN    = r_stream_en;
    assign SAMPLE_RATE  = r_sample_rate;

    // Host command decode; a corrupted byte is never interpreted, only NAKed.
    always_comb begin
        w_rsp_buf    = {c_RESEND, 16'h0000};
        w_rsp_cnt    = 2'd1;
        w_stream_nxt = r_stream_en;
        w_rate_nxt   = r_sample_rate;
`ifdef MOUSE_DEV_SETRATE_EN
        w_arg_nxt    = 1'b0;
`endif
        if (BYTE_ERROR_CODE == 2'b00) begin
            case (BYTE_READ)
                8'hFF: begin
                    w_rsp_buf    = {c_ACK, c_BAT_OK, c_DEV_ID};
                    w_rsp_cnt    = 2'd3;
                    w_stream_nxt = 1'b0;
                    w_rate_nxt   = c_RATE_DFLT;
                end
                8'hF4: begin
                    w_rsp_buf    = {c_ACK, 16'h0000};
                    w_stream_nxt = 1'b1;
                end
                8'hF5: begin
                    w_rsp_buf    = {c_ACK, 16'h0000};
                    w_stream_nxt = 1'b0;
                end
                8'hF2: begin
                    w_rsp_buf = {c_ACK, c_DEV_ID, 8'h00};
                    w_rsp_cnt = 2'd2;
                end
`ifdef MOUSE_DEV_SETRATE_EN
                8'hF3: begin
                    w_rsp_buf = {c_ACK, 16'h0000};
                    w_arg_nxt = 1'b1;
                end
`endif
                default: begin
                    w_rsp_buf = {c_RESEND, 16'h0000};
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state        <= S_BAT_WAIT;
            r_q_buf        <= 24'h000000;
            r_q_cnt        <= 2'd0;
            r_bat_cnt      <= 16'd0;
            r_to_cnt       <= 16'd0;
            r_send_byte    <= 1'b0;
            r_byte_to_send <= 8'h00;
            r_read_enable  <= 1'b0;
            r_move_accept  <= 1'b0;
            r_stream_en    <= 1'b0;
            r_sample_rate  <= c_RATE_DFLT;
`ifdef MOUSE_DEV_SETRATE_EN
            r_arg_pend     <= 1'b0;
`endif
        end else begin
            r_send_byte   <= 1'b0;
            r_move_accept <= 1'b0;
            case (r_state)
                S_BAT_WAIT: begin
                    if (r_bat_cnt == BAT_DELAY) begin
                        r_q_buf <= {c_BAT_OK, c_DEV_ID, 8'h00};
                        r_q_cnt <= 2'd2;
                        r_state <= S_TX_LOAD;
                    end else begin
                        r_bat_cnt <= r_bat_cnt + 16'd1;
                    end
                end
                S_IDLE: begin
                    if (BYTE_READY) begin
                        r_q_buf       <= w_rsp_buf;
                        r_q_cnt       <= w_rsp_cnt;
                        r_stream_en   <= w_stream_nxt;
                        r_sample_rate <= w_rate_nxt;
`ifdef MOUSE_DEV_SETRATE_EN
                        r_arg_pend    <= w_arg_nxt;
`endif
                        r_read_enable <= 1'b0;
                        r_state       <= S_TX_LOAD;
                    end else if (r_stream_en && MOVE_VALID) begin
                        // Bit 3 of the status byte is always set in PS/2 packets.
                        r_q_buf       <= {MOVE_STATUS | 8'h08, MOVE_DX, MOVE_DY};
                        r_q_cnt       <= 2'd3;
                        r_move_accept <= 1'b1;
                        r_read_enable <= 1'b0;
                        r_state       <= S_TX_LOAD;
                    end
                end
                S_TX_LOAD: begin
                    r_byte_to_send <= r_q_buf[23:16];
                    r_send_byte    <= 1'b1;
                    r_to_cnt       <= 16'd0;
                    r_state        <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (BYTE_SENT) begin
                        r_q_buf <= {r_q_buf[15:0], 8'h00};
                        r_q_cnt <= r_q_cnt - 2'd1;
                        if (r_q_cnt == 2'd1) begin
                            r_read_enable <= 1'b1;
`ifdef MOUSE_DEV_SETRATE_EN
                            r_state       <= r_arg_pend ? S_WAIT_ARG : S_IDLE;
`else
                            r_state       <= S_IDLE;
`endif
                        end else begin
                            r_state <= S_TX_LOAD;
                        end
                    end else if (r_to_cnt == TX_TIMEOUT) begin
                        r_q_buf       <= 24'h000000;
                        r_q_cnt       <= 2'd0;
                        r_read_enable <= 1'b1;
                        r_state       <= S_IDLE;
`ifdef MOUSE_DEV_SETRATE_EN
                        r_arg_pend    <= 1'b0;
`endif
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
`ifdef MOUSE_DEV_SETRATE_EN
                S_WAIT_ARG: begin
                    if (BYTE_READY) begin
                        if (BYTE_ERROR_CODE == 2'b00) begin
                            r_sample_rate <= BYTE_READ;
                            r_q_buf       <= {c_ACK, 16'h0000};
                        end else begin
                            r_q_buf       <= {c_RESEND, 16'h0000};
                        end
                        r_q_cnt       <= 2'd1;
                        r_arg_pend    <= 1'b0;
                        r_read_enable <= 1'b0;
                        r_state       <= S_TX_LOAD;
                    end
                end
`endif
                default: begin
                    r_read_enable <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mouse_device_sm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mouse_device_sm
// Purpose  : Scoreboard bench for mouse_device_sm with a host driver and a
//            transmitter model that acknowledges each byte after 10 cycles.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mouse_device_sm;

    localparam int c_BAT = 20;
    localparam int c_TO  = 40;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic       MOVE_VALID = 1'b0;
    logic [7:0] MOVE_STATUS = 8'h00;
    logic [7:0] MOVE_DX = 8'h00;
    logic [7:0] MOVE_DY = 8'h00;
    logic       MOVE_ACCEPT;
    logic       STREAM_EN;
    logic [7:0] SAMPLE_RATE;

    mouse_device_sm #(
        .BAT_DELAY (16'(c_BAT)),
        .TX_TIMEOUT(16'(c_TO))
    ) u_dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SEND_BYTE      (SEND_BYTE),
        .BYTE_TO_SEND   (BYTE_TO_SEND),
        .BYTE_SENT      (BYTE_SENT),
        .READ_ENABLE    (READ_ENABLE),
        .BYTE_READ      (BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY     (BYTE_READY),
        .MOVE_VALID     (MOVE_VALID),
        .MOVE_STATUS    (MOVE_STATUS),
        .MOVE_DX        (MOVE_DX),
        .MOVE_DY        (MOVE_DY),
        .MOVE_ACCEPT    (MOVE_ACCEPT),
        .STREAM_EN      (STREAM_EN),
        .SAMPLE_RATE    (SAMPLE_RATE)
    );

    always #5 CLK = ~CLK;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int accept_cnt = 0;
    int resp_cnt = 0;
    bit resp_en = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every transmitted byte must match the next expected one.
    always @(negedge CLK) begin
        if (RESET && SEND_BYTE) begin
            if (exp_q.size() == 0) check_val("tx_unexpected", 32'(BYTE_TO_SEND), 32'hFFFF_FFFF);
            else check_val("tx_byte", 32'(BYTE_TO_SEND), 32'(exp_q.pop_front()));
        end
        if (MOVE_ACCEPT) accept_cnt++;
    end

    // Transmitter model: BYTE_SENT one cycle, 10 cycles after each request.
    always @(negedge CLK) begin
        BYTE_SENT = 1'b0;
        if (!RESET) resp_cnt = 0;
        else if (SEND_BYTE && resp_en) resp_cnt = 10;
        else if (resp_cnt != 0) begin
            resp_cnt--;
            if (resp_cnt == 0) BYTE_SENT = 1'b1;
        end
    end

    task automatic expect_cmd(input logic [7:0] cmd, input logic [1:0] err);
        if (err != 2'b00) exp_q.push_back(8'hFE);
        else begin
            case (cmd)
                8'hFF: begin exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00); end
                8'hF4, 8'hF5: exp_q.push_back(8'hFA);
                8'hF2: begin exp_q.push_back(8'hFA); exp_q.push_back(8'h00); end
`ifdef MOUSE_DEV_SETRATE_EN
                8'hF3: exp_q.push_back(8'hFA);
`endif
                default: exp_q.push_back(8'hFE);
            endcase
        end
    endtask

    task automatic send_cmd(input logic [7:0] b, input logic [1:0] e);
        int i = 0;
        while (i < 300 && !READ_ENABLE) begin @(negedge CLK); i++; end
        check_val("host_ready", 32'(READ_ENABLE), 32'd1);
        BYTE_READ = b; BYTE_ERROR_CODE = e; BYTE_READY = 1'b1;
        @(negedge CLK);
        BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (i < 400 && !(exp_q.size() == 0 && READ_ENABLE)) begin @(negedge CLK); i++; end
        check_val(tag, 32'(exp_q.size() == 0 && READ_ENABLE), 32'd1);
        exp_q.delete();
    endtask

    task automatic wait_accept();
        int i = 0;
        while (i < 300 && !MOVE_ACCEPT) begin @(negedge CLK); i++; end
        check_val("accept_seen", 32'(MOVE_ACCEPT), 32'd1);
        MOVE_VALID = 1'b0;
    endtask

    initial begin
        int lat;
        int a0;
        repeat (3) @(negedge CLK);
        check_val("rst_send", 32'(SEND_BYTE), 32'd0);
        check_val("rst_byte", 32'(BYTE_TO_SEND), 32'h00);
        check_val("rst_rden", 32'(READ_ENABLE), 32'd0);
        check_val("rst_macc", 32'(MOVE_ACCEPT), 32'd0);
        check_val("rst_stream", 32'(STREAM_EN), 32'd0);
        check_val("rst_rate", 32'(SAMPLE_RATE), 32'h64);

        // Power-on BAT
        exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
        RESET = 1'b1;
        lat = 0;
        while (lat < 200 && !SEND_BYTE) begin @(negedge CLK); lat++; end
        check_val("bat_latency", 32'(lat >= c_BAT && lat <= c_BAT + 3), 32'd1);
        wait_idle("bat_done");
        check_val("bat_stream", 32'(STREAM_EN), 32'd0);
        check_val("bat_rate", 32'(SAMPLE_RATE), 32'h64);

        // Reset command
        expect_cmd(8'hFF, 2'b00); send_cmd(8'hFF, 2'b00);
        wait_idle("ff_done");
        check_val("ff_stream", 32'(STREAM_EN), 32'd0);

        // Enable streaming then one packet
        expect_cmd(8'hF4, 2'b00); send_cmd(8'hF4, 2'b00);
        wait_idle("f4_done");
        check_val("f4_stream", 32'(STREAM_EN), 32'd1);
        a0 = accept_cnt;
        exp_q.push_back(8'h09); exp_q.push_back(8'h05); exp_q.push_back(8'hFB);
        MOVE_STATUS = 8'h01; MOVE_DX = 8'h05; MOVE_DY = 8'hFB; MOVE_VALID = 1'b1;
        wait_accept();
        wait_idle("pkt1_done");
        check_val("pkt1_accepts", 32'(accept_cnt - a0), 32'd1);

        // Command and movement in the same cycle: command wins
        a0 = accept_cnt;
        expect_cmd(8'hF4, 2'b00);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        MOVE_STATUS = 8'h02; MOVE_DX = 8'h10; MOVE_DY = 8'h20; MOVE_VALID = 1'b1;
        send_cmd(8'hF4, 2'b00);
        check_val("same_cyc_noacc", 32'(MOVE_ACCEPT), 32'd0);
        wait_accept();
        wait_idle("same_cyc_done");
        check_val("same_cyc_accepts", 32'(accept_cnt - a0), 32'd1);

        // Streaming off: sample must stay with the source
        expect_cmd(8'hF5, 2'b00); send_cmd(8'hF5, 2'b00);
        wait_idle("f5_done");
        check_val("f5_stream", 32'(STREAM_EN), 32'd0);
        a0 = accept_cnt;
        MOVE_VALID = 1'b1;
        repeat (30) @(negedge CLK);
        MOVE_VALID = 1'b0;
        check_val("off_no_accept", 32'(accept_cnt - a0), 32'd0);

        // Unknown command and corrupted byte
        expect_cmd(8'hEE, 2'b00); send_cmd(8'hEE, 2'b00);
        wait_idle("ee_done");
        expect_cmd(8'h12, 2'b01); send_cmd(8'h12, 2'b01);
        wait_idle("err_done");

`ifdef MOUSE_DEV_SETRATE_EN
        expect_cmd(8'hF3, 2'b00); send_cmd(8'hF3, 2'b00);
        wait_idle("f3_done");
        exp_q.push_back(8'hFA); send_cmd(8'h28, 2'b00);
        wait_idle("f3_arg_done");
        check_val("f3_rate", 32'(SAMPLE_RATE), 32'h28);
`else
        expect_cmd(8'hF3, 2'b00); send_cmd(8'hF3, 2'b00);
        wait_idle("f3_done");
        check_val("f3_rate", 32'(SAMPLE_RATE), 32'h64);
`endif

        // Transmitter never finishes: queue must be abandoned
        resp_en = 1'b0;
        exp_q.push_back(8'hFA);
        send_cmd(8'hFF, 2'b00);
        wait_idle("timeout_idle");
        check_val("timeout_rden", 32'(READ_ENABLE), 32'd1);
        resp_en = 1'b1;
        expect_cmd(8'hF2, 2'b00); send_cmd(8'hF2, 2'b00);
        wait_idle("f2_done");

        // Reset during a transmission request
        exp_q.push_back(8'hFA);
        send_cmd(8'hF4, 2'b00);
        lat = 0;
        while (lat < 50 && !SEND_BYTE) begin @(negedge CLK); lat++; end
        check_val("midrst_sendseen", 32'(SEND_BYTE), 32'd1);
        RESET = 1'b0;
        #1;
        check_val("midrst_send", 32'(SEND_BYTE), 32'd0);
        check_val("midrst_stream", 32'(STREAM_EN), 32'd0);
        check_val("midrst_byte", 32'(BYTE_TO_SEND), 32'h00);
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
